// File: rtl/sobel_3x3_stage.sv
// Pipelined 3x3 Sobel edge-magnitude stage with frame tracking (IDLE/RUN/DRAIN/DONE).
// Optional: define SOBEL_THRESH_EN to add i_thresh and binarise the output to 0/255.
module sobel_3x3_stage #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  input  logic [7:0] i_p1,
  input  logic [7:0] i_p2,
  input  logic [7:0] i_p3,
  input  logic [7:0] i_p4,
  input  logic [7:0] i_p5,
  input  logic [7:0] i_p6,
  input  logic [7:0] i_p7,
  input  logic [7:0] i_p8,
  input  logic [7:0] i_p9,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0] i_thresh,
`endif
  output logic       o_out_valid,
  output logic [7:0] o_out_pixel,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);

  localparam int unsigned Total = IMG_W * IMG_H;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam logic [CntW-1:0] TotalCnt = CntW'(Total);
  localparam logic [CntW-1:0] LastCol  = CntW'(IMG_W - 1);
  localparam logic [CntW-1:0] LastRow  = CntW'(IMG_H - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_d;
  logic              w_accept;
  logic [CntW-1:0]   r_in_cnt, r_col_cnt, r_row_cnt, w_in_cnt_inc;
  logic              r_overrun;

  logic [8:0][7:0]   r_win;
  logic              r_v0, r_v1, r_v2, r_out_valid;
  logic [10:0]       w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [10:0] w_gx, w_gy, r_gx, r_gy;
  logic [10:0]       w_abs_gx, w_abs_gy, r_mag;
  logic [7:0]        w_pix, r_out_pixel;

  // Datapath: S0 window capture, S1 gradients, S2 magnitude, S3 output pixel.
  always_comb begin
    w_gx_pos = 11'(r_win[2]) + {2'b00, r_win[5], 1'b0} + 11'(r_win[8]);
    w_gx_neg = 11'(r_win[0]) + {2'b00, r_win[3], 1'b0} + 11'(r_win[6]);
    w_gy_pos = 11'(r_win[6]) + {2'b00, r_win[7], 1'b0} + 11'(r_win[8]);
    w_gy_neg = 11'(r_win[0]) + {2'b00, r_win[1], 1'b0} + 11'(r_win[2]);
    w_gx     = $signed(w_gx_pos) - $signed(w_gx_neg);
    w_gy     = $signed(w_gy_pos) - $signed(w_gy_neg);
    w_abs_gx = r_gx[10] ? unsigned'(-r_gx) : unsigned'(r_gx);
    w_abs_gy = r_gy[10] ? unsigned'(-r_gy) : unsigned'(r_gy);
`ifdef SOBEL_THRESH_EN
    w_pix    = (r_mag >= {3'b000, i_thresh}) ? 8'hFF : 8'h00;
`else
    w_pix    = (r_mag > 11'd255) ? 8'hFF : r_mag[7:0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win       <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_mag       <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= 8'h00;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) r_win <= {i_p9, i_p8, i_p7, i_p6, i_p5, i_p4, i_p3, i_p2, i_p1};
      r_v1        <= r_v0;
      r_gx        <= w_gx;
      r_gy        <= w_gy;
      r_v2        <= r_v1;
      r_mag       <= w_abs_gx + w_abs_gy;
      r_out_valid <= r_v2;
      r_out_pixel <= r_v2 ? w_pix : 8'h00;
    end
  end

  assign w_in_cnt_inc = r_in_cnt + CntOne;

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_accept  = 1'b1;
          w_state_d = (w_in_cnt_inc == TotalCnt) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (i_in_valid) begin
          w_accept = 1'b1;
          if (w_in_cnt_inc == TotalCnt) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (r_out_valid && r_col_cnt == LastCol && r_row_cnt == LastRow) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_in_cnt  <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StDone) begin
        r_in_cnt  <= '0;
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end else begin
        if (w_accept) r_in_cnt <= w_in_cnt_inc;
        if (r_out_valid) begin
          if (r_col_cnt == LastCol) begin
            r_col_cnt <= '0;
            r_row_cnt <= (r_row_cnt == LastRow) ? '0 : r_row_cnt + CntOne;
          end else begin
            r_col_cnt <= r_col_cnt + CntOne;
          end
        end
      end
      // Windows arriving while draining or finishing are dropped and flagged.
      if (i_in_valid && (r_state == StDrain || r_state == StDone)) r_overrun <= 1'b1;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_pixel  = r_out_pixel;
  assign o_busy       = (r_state == StRun) || (r_state == StDrain);
  assign o_frame_done = (r_state == StDone);
  assign o_overrun    = r_overrun;

endmodule
